// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - VLIW bundle and cacheline constants shared by the line packer and fetch stage 2
package vliw_pkg;

   localparam logic FMT_19 = 1'b0;
   localparam logic FMT_30 = 1'b1;

   localparam int INSTR19_W  = 19;
   localparam int INSTR30_W  = 30;
   localparam int LINE_BYTES = 32;

   localparam logic [3:0] BUNDLE_BYTES_88 = 4'd8;
   localparam logic [3:0] BUNDLE_BYTES_87 = 4'd7;
   localparam logic [3:0] BUNDLE_BYTES_78 = 4'd7;
   localparam logic [3:0] BUNDLE_BYTES_55 = 4'd5;

   typedef enum logic {
      FILL = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Byte footprint of a bundle; must agree with fetch nextByteOffset.
   function automatic logic [3:0] bundle_bytes(input logic fmt_a, input logic fmt_b);
      logic [3:0] bytes;
      case ({fmt_a, fmt_b})
         {FMT_30, FMT_30}: bytes = BUNDLE_BYTES_88;
         {FMT_30, FMT_19}: bytes = BUNDLE_BYTES_87;
         {FMT_19, FMT_30}: bytes = BUNDLE_BYTES_78;
         default:          bytes = BUNDLE_BYTES_55;
      endcase
      return bytes;
   endfunction

endpackage

// File: rtl/vliw_bundle_encoder.sv
// rtl/vliw_bundle_encoder.sv - packs one (A, B) instruction pair MSB-first into a 64-bit bundle image
module vliw_bundle_encoder
   import vliw_pkg::*;
(
   input  logic [31:0] i_instr_a,
   input  logic [31:0] i_instr_b,
   input  logic        i_fmt_a,
   input  logic        i_fmt_b,
   output logic [0:63] o_bundle,
   output logic [3:0]  o_size,
   output logic        o_fmt_err
);

   logic w_err_a;
   logic w_err_b;
   logic w_unused;

   // Ascending bundle range: the instruction MSB (format bit) lands on the lowest index.
   always_comb begin
      o_bundle = '0;
      if (i_fmt_a == FMT_30) begin
         o_bundle[0 +: INSTR30_W] = i_instr_a[INSTR30_W-1:0];
         if (i_fmt_b == FMT_30) o_bundle[INSTR30_W +: INSTR30_W] = i_instr_b[INSTR30_W-1:0];
         else                   o_bundle[INSTR30_W +: INSTR19_W] = i_instr_b[INSTR19_W-1:0];
      end else begin
         o_bundle[0 +: INSTR19_W] = i_instr_a[INSTR19_W-1:0];
         if (i_fmt_b == FMT_30) o_bundle[INSTR19_W +: INSTR30_W] = i_instr_b[INSTR30_W-1:0];
         else                   o_bundle[INSTR19_W +: INSTR19_W] = i_instr_b[INSTR19_W-1:0];
      end
   end

   assign w_err_a   = (i_fmt_a == FMT_30) ? !i_instr_a[INSTR30_W-1] : i_instr_a[INSTR19_W-1];
   assign w_err_b   = (i_fmt_b == FMT_30) ? !i_instr_b[INSTR30_W-1] : i_instr_b[INSTR19_W-1];
   assign o_fmt_err = w_err_a | w_err_b;
   assign o_size    = bundle_bytes(i_fmt_a, i_fmt_b);

   assign w_unused  = ^{i_instr_a[31:30], i_instr_b[31:30]};

endmodule

// File: rtl/vliw_line_packer.sv
// rtl/vliw_line_packer.sv - packs VLIW bundles into 256-bit cachelines for instruction memory
module vliw_line_packer
   import vliw_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int START_LINE = 0
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              bundleValid_i,
   output logic              bundleReady_o,
   input  logic [31:0]       InstructionA_i,
   input  logic [31:0]       InstructionB_i,
   input  logic              InstructionAFormat_i,
   input  logic              InstructionBFormat_i,
   input  logic              flush_i,
   output logic              lineValid_o,
   input  logic              lineReady_i,
   output logic [0:255]      line_o,
   output logic [5:0]        lineUsedBytes_o,
   output logic [ADDR_W-1:0] lineAddr_o,
   output logic              formatError_o
);

   state_t            r_state;
   logic [5:0]        r_off;
   logic [0:255]      r_buf;
   logic [ADDR_W-1:0] r_addr;
   logic              r_fmt_err;

   state_t            w_state_nx;
   logic [0:63]       w_bundle;
   logic [3:0]        w_size;
   logic              w_err;
   logic [6:0]        w_sum;
   logic              w_fits;
   logic              w_ready;
   logic              w_accept;
   logic              w_write;
   logic              w_pop;
   logic              w_line_valid;
   logic [5:0]        w_off_nx;
   logic [0:255]      w_buf_wr;

   vliw_bundle_encoder u_enc (
      .i_instr_a (InstructionA_i),
      .i_instr_b (InstructionB_i),
      .i_fmt_a   (InstructionAFormat_i),
      .i_fmt_b   (InstructionBFormat_i),
      .o_bundle  (w_bundle),
      .o_size    (w_size),
      .o_fmt_err (w_err)
   );

   assign w_sum  = {1'b0, r_off} + {3'b000, w_size};
   assign w_fits = (w_sum <= 7'(LINE_BYTES));

   // Lanes past the bundle size keep their old contents; wrapped lanes only occur when the bundle does not fit and nothing is committed.
   always_comb begin
      w_buf_wr = r_buf;
      for (int k = 0; k < 8; k++) begin
         if (4'(k) < w_size) begin
            w_buf_wr[{r_off[4:0] + 5'(k), 3'b000} +: 8] = w_bundle[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) r_state <= FILL;
      else          r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx   = r_state;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_write      = 1'b0;
      w_pop        = 1'b0;
      w_line_valid = 1'b0;
      w_off_nx     = r_off;
      case (r_state)
         FILL: begin
            w_ready  = !bundleValid_i || w_fits;
            w_accept = bundleValid_i && w_fits;
            w_write  = w_accept && !w_err;
            if (w_write) w_off_nx = w_sum[5:0];
            // Flush looks at the offset after this cycle's bundle so that bundle closes with the line.
            if (bundleValid_i && !w_fits)                 w_state_nx = EMIT;
            else if (w_write && w_sum == 7'(LINE_BYTES))  w_state_nx = EMIT;
            else if (flush_i && w_off_nx != 6'd0)         w_state_nx = EMIT;
         end
         EMIT: begin
            w_line_valid = 1'b1;
            if (lineReady_i) begin
               w_pop      = 1'b1;
               w_state_nx = FILL;
            end
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         r_off     <= '0;
         r_buf     <= '0;
         r_addr    <= ADDR_W'(START_LINE);
         r_fmt_err <= 1'b0;
      end else begin
         r_fmt_err <= w_accept & w_err;
         if (w_pop) begin
            r_off  <= '0;
            r_buf  <= '0;
            r_addr <= r_addr + 1'b1;
         end else if (w_write) begin
            r_off  <= w_off_nx;
            r_buf  <= w_buf_wr;
         end
      end
   end

   assign bundleReady_o   = w_ready;
   assign lineValid_o     = w_line_valid;
   assign line_o          = r_buf;
   assign lineUsedBytes_o = r_off;
   assign lineAddr_o      = r_addr;
   assign formatError_o   = r_fmt_err;

endmodule
